sensor_scan_scheduler: RTL and testbench

- Time-multiplexes one shared sensor ADC across NUM_CH protection channels, in round-robin order.
- For each channel: starts a conversion, waits for it to finish (with a timeout), latches the 16-bit result into that channel's sample register, then pulses the channel's enable so its per-channel protection FSM evaluates exactly one fresh sample.
- Sits between the ADC interface and the bank of per-channel relay/protection FSMs.
- Runs on the 16 ms tick domain.

---
 rtl/sensor_scan_scheduler_pkg.sv | 28 ++
 rtl/sensor_scan_scheduler_sat_counter.sv | 30 +++
 rtl/sensor_scan_scheduler.sv | 173 +++++++++++++++++
 tb/tb_sensor_scan_scheduler.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_scan_scheduler_pkg.sv
// Shared constants and state encoding for the sensor ADC scan scheduler.
package sensor_scan_scheduler_pkg;

  localparam int DATA_W       = 16;
  localparam int CNT_W        = 8;
  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_TIMEOUT  = 8;
  localparam int DEF_SCAN_GAP = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_LATCH  = 3'd4;
  localparam logic [2:0] ST_NEXT   = 3'd5;
  localparam logic [2:0] ST_GAP    = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    SELECT = ST_SELECT,
    START  = ST_START,
    WAIT   = ST_WAIT,
    LATCH  = ST_LATCH,
    NEXT   = ST_NEXT,
    GAP    = ST_GAP
  } state_t;

endpackage

// File: rtl/sensor_scan_scheduler_sat_counter.sv
// Saturating up-counter with synchronous clear and a fixed terminal-count flag.
module sat_counter
  import sensor_scan_scheduler_pkg::*;
#(
  parameter int         W  = CNT_W,
  parameter logic [W-1:0] TC = '0
)(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [W-1:0] count_r;

  // Clear has priority over increment; the count holds once it reaches all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1);
    end
  end

  assign tc = (count_r == TC);

endmodule

// File: rtl/sensor_scan_scheduler.sv
// Round-robin scheduler sharing one sensor ADC across NUM_CH protection channels.
// Latches each result and strobes that channel's protection FSM once per fresh sample.
module sensor_scan_scheduler
  import sensor_scan_scheduler_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int SCAN_GAP = DEF_SCAN_GAP,
  localparam int CW      = $clog2(NUM_CH)
)(
  input  logic                     clk_16ms,
  input  logic                     rst,
  input  logic                     run,
  input  logic [NUM_CH-1:0]        ch_skip,
  input  logic                     err_clr,
  output logic                     adc_start,
  output logic [CW-1:0]            adc_ch,
  input  logic                     adc_done,
  input  logic [DATA_W-1:0]        adc_data,
  output logic [DATA_W*NUM_CH-1:0] ch_sample,
  output logic [NUM_CH-1:0]        ch_enable,
  output logic [NUM_CH-1:0]        adc_err,
  output logic                     scan_done,
  output logic                     busy
);

  localparam logic [CW-1:0]    LAST_CH  = CW'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] TIMER_TC = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_TC   = (SCAN_GAP == 0) ? {CNT_W{1'b0}} : CNT_W'(SCAN_GAP - 1);

  state_t            state_r;
  logic [CW-1:0]     ch_idx_r;
  logic              last_ch_s;
  logic              timer_tc_s;
  logic              gap_tc_s;
  logic              sample_we_s;
  logic [NUM_CH-1:0] idx_onehot_s;
  logic [NUM_CH-1:0] err_set_s;

  assign last_ch_s    = (ch_idx_r == LAST_CH);
  assign idx_onehot_s = {{(NUM_CH-1){1'b0}}, 1'b1} << ch_idx_r;

  sat_counter #(.W(CNT_W), .TC(TIMER_TC)) u_timeout (
    .clk (clk_16ms),
    .rst (rst),
    .clr (state_r == START),
    .inc (state_r == WAIT),
    .tc  (timer_tc_s)
  );

  sat_counter #(.W(CNT_W), .TC(GAP_TC)) u_gap (
    .clk (clk_16ms),
    .rst (rst),
    .clr (state_r == NEXT),
    .inc (state_r == GAP),
    .tc  (gap_tc_s)
  );

  // WAIT outcome decode: a done strobe beats a timeout landing in the same cycle.
  always_comb begin
    sample_we_s = 1'b0;
    err_set_s   = {NUM_CH{1'b0}};
    if (state_r == WAIT) begin
      sample_we_s = adc_done;
      if (!adc_done && timer_tc_s) begin
        err_set_s = idx_onehot_s;
      end else begin
        err_set_s = {NUM_CH{1'b0}};
      end
    end else begin
      sample_we_s = 1'b0;
      err_set_s   = {NUM_CH{1'b0}};
    end
  end

  // Scan sequencer; strobes are asserted while sitting in the state they belong to.
  always_ff @(posedge clk_16ms or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      ch_idx_r  <= '0;
      adc_start <= 1'b0;
      adc_ch    <= '0;
      ch_enable <= {NUM_CH{1'b0}};
      scan_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      adc_start <= 1'b0;
      ch_enable <= {NUM_CH{1'b0}};
      scan_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (run) begin
            state_r  <= SELECT;
            ch_idx_r <= '0;
            busy     <= 1'b1;
          end
        end
        SELECT: begin
          if (ch_skip[ch_idx_r]) begin
            state_r   <= NEXT;
            scan_done <= last_ch_s;
          end else begin
            state_r   <= START;
            adc_ch    <= ch_idx_r;
            adc_start <= 1'b1;
          end
        end
        START: state_r <= WAIT;
        WAIT: begin
          if (adc_done) begin
            state_r   <= LATCH;
            ch_enable <= idx_onehot_s;
          end else if (timer_tc_s) begin
            state_r   <= NEXT;
            scan_done <= last_ch_s;
          end
        end
        LATCH: begin
          state_r   <= NEXT;
          scan_done <= last_ch_s;
        end
        NEXT: begin
          if (!last_ch_s) begin
            ch_idx_r <= ch_idx_r + CW'(1);
            state_r  <= SELECT;
          end else begin
            // Run is only honoured here, so a scan in flight is never cut short.
            ch_idx_r <= '0;
            if (!run) begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end else if (SCAN_GAP == 0) begin
              state_r <= SELECT;
            end else begin
              state_r <= GAP;
            end
          end
        end
        GAP: begin
          if (!run) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else if (gap_tc_s) begin
            state_r <= SELECT;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Result capture; the register already holds the new value while ch_enable is high.
  always_ff @(posedge clk_16ms or posedge rst) begin
    if (rst) begin
      ch_sample <= '0;
    end else if (sample_we_s) begin
      ch_sample[DATA_W*int'(ch_idx_r) +: DATA_W] <= adc_data;
    end
  end

  // Sticky timeout flags; a new timeout survives a simultaneous clear.
  always_ff @(posedge clk_16ms or posedge rst) begin
    if (rst) begin
      adc_err <= {NUM_CH{1'b0}};
    end else begin
      adc_err <= (err_clr ? {NUM_CH{1'b0}} : adc_err) | err_set_s;
    end
  end

endmodule

// File: tb/tb_sensor_scan_scheduler.sv
// Directed bench for sensor_scan_scheduler with a small ADC responder and event monitor.
module tb_sensor_scan_scheduler;

  logic        clk_16ms = 1'b0;
  logic        rst;
  logic        run;
  logic [3:0]  ch_skip;
  logic        err_clr;
  logic        adc_start;
  logic [1:0]  adc_ch;
  logic        adc_done;
  logic [15:0] adc_data;
  logic [63:0] ch_sample;
  logic [3:0]  ch_enable;
  logic [3:0]  adc_err;
  logic        scan_done;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // ADC model controls (written by tests only)
  int         delay       = 3;
  int         data_base   = 350;
  logic [3:0] no_answer   = 4'b0000;
  int         stray_req_n = 0;
  int         stray_ack_n = 0;

  // Monitor state (written by monitor only)
  int cyc = 0;
  int start_cnt = 0;
  int scan_cnt = 0;
  int bad_cnt = 0;
  int start_ch_cnt[4];
  int start_cyc_last[4];
  int en_cnt[4];
  int en_cyc_last[4];
  int scan_cyc_last = 0;
  int scan_prev_cyc = 0;
  int err_chg_cyc = 0;
  int busy_fall_cyc = 0;

  sensor_scan_scheduler #(.NUM_CH(4), .TIMEOUT(8), .SCAN_GAP(4)) dut (
    .clk_16ms  (clk_16ms),
    .rst       (rst),
    .run       (run),
    .ch_skip   (ch_skip),
    .err_clr   (err_clr),
    .adc_start (adc_start),
    .adc_ch    (adc_ch),
    .adc_done  (adc_done),
    .adc_data  (adc_data),
    .ch_sample (ch_sample),
    .ch_enable (ch_enable),
    .adc_err   (adc_err),
    .scan_done (scan_done),
    .busy      (busy)
  );

  always #5 clk_16ms = ~clk_16ms;

  // ADC responder: done arrives 'delay' cycles after the cycle adc_start is seen
  initial begin : adc_model
    int         cnt;
    logic       pend;
    logic [1:0] pch;
    cnt = 0; pend = 1'b0; pch = 2'd0;
    adc_done = 1'b0;
    adc_data = 16'd0;
    forever begin
      @(negedge clk_16ms);
      adc_done = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          adc_done = 1'b1;
          adc_data = 16'(data_base + 16 * int'(pch));
          pend = 1'b0;
        end
      end
      if (stray_req_n != stray_ack_n) begin
        adc_done = 1'b1;
        adc_data = 16'hDEAD;
        stray_ack_n = stray_req_n;
      end
      if (adc_start) begin
        pend = !no_answer[adc_ch];
        cnt  = delay;
        pch  = adc_ch;
      end
    end
  end

  initial begin : monitor
    logic [3:0] err_prev;
    logic       busy_prev;
    err_prev = 4'd0; busy_prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_ch_cnt[i] = 0; start_cyc_last[i] = 0; en_cnt[i] = 0; en_cyc_last[i] = 0;
    end
    forever begin
      @(negedge clk_16ms);
      cyc++;
      if (adc_start) begin
        start_cnt++;
        start_ch_cnt[adc_ch]++;
        start_cyc_last[adc_ch] = cyc;
      end
      for (int i = 0; i < 4; i++) begin
        if (ch_enable[i]) begin
          en_cnt[i]++;
          en_cyc_last[i] = cyc;
        end
      end
      if (($countones(ch_enable) > 1) || ((ch_enable != 4'd0) && adc_start)) bad_cnt++;
      if (scan_done) begin
        scan_prev_cyc = scan_cyc_last;
        scan_cyc_last = cyc;
        scan_cnt++;
      end
      if (adc_err != err_prev) err_chg_cyc = cyc;
      err_prev = adc_err;
      if (busy_prev && !busy) busy_fall_cyc = cyc;
      busy_prev = busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_16ms);
      #1;
    end
  endtask

  task automatic wait_scan(input int budget, input string tag);
    int s0, n;
    s0 = scan_cnt; n = 0;
    while (scan_cnt == s0 && n < budget) begin tick(1); n++; end
    n_checks++;
    if (scan_cnt == s0) $display("FAIL %s: scan_done not seen within %0d cycles", tag, budget);
    else n_pass++;
  endtask

  task automatic wait_start(input int budget, input string tag);
    int s0, n;
    s0 = start_cnt; n = 0;
    while (start_cnt == s0 && n < budget) begin tick(1); n++; end
    n_checks++;
    if (start_cnt == s0) $display("FAIL %s: adc_start not seen within %0d cycles", tag, budget);
    else n_pass++;
  endtask

  task automatic stop_scan(input string tag);
    int n;
    run = 1'b0; n = 0;
    while (busy !== 1'b0 && n < 200) begin tick(1); n++; end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s: busy still %b after 200 cycles", tag, busy);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1; run = 1'b0; ch_skip = 4'd0; err_clr = 1'b0;
    tick(2);
    n_checks++;
    if ({adc_start, ch_enable, scan_done, busy} !== 7'd0)
      $display("FAIL reset_strobes: got %b want 0", {adc_start, ch_enable, scan_done, busy});
    else n_pass++;
    n_checks++;
    if (ch_sample !== 64'd0) $display("FAIL reset_sample: got %h want 0", ch_sample);
    else n_pass++;
    n_checks++;
    if ({adc_err, adc_ch} !== 6'd0) $display("FAIL reset_err_ch: got %b want 0", {adc_err, adc_ch});
    else n_pass++;
    rst = 1'b0;
    tick(3);
    n_checks++;
    if ({busy, adc_start} !== 2'b00) $display("FAIL idle_no_run: got %b want 00", {busy, adc_start});
    else n_pass++;
  endtask

  task automatic test_basic_scan;
    int e0[4];
    logic [3:0] em;
    for (int i = 0; i < 4; i++) e0[i] = en_cnt[i];
    delay = 3; data_base = 350; no_answer = 4'd0; ch_skip = 4'd0;
    run = 1'b1;
    wait_scan(100, "basic_wait");
    n_checks++;
    if (ch_sample !== {16'd398, 16'd382, 16'd366, 16'd350})
      $display("FAIL basic_sample: got %h want 018e_017e_016e_015e", ch_sample);
    else n_pass++;
    for (int i = 0; i < 4; i++) em[i] = (en_cnt[i] - e0[i] == 1);
    n_checks++;
    if (em !== 4'b1111) $display("FAIL basic_enable_once: got %b want 1111", em);
    else n_pass++;
    n_checks++;
    if (((en_cyc_last[0] < en_cyc_last[1]) && (en_cyc_last[1] < en_cyc_last[2]) &&
         (en_cyc_last[2] < en_cyc_last[3])) !== 1'b1)
      $display("FAIL basic_enable_order: cycles %0d %0d %0d %0d not increasing",
               en_cyc_last[0], en_cyc_last[1], en_cyc_last[2], en_cyc_last[3]);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (en_cyc_last[i] - start_cyc_last[i] !== 4)
        $display("FAIL basic_latency_ch%0d: got %0d want 4", i, en_cyc_last[i] - start_cyc_last[i]);
      else n_pass++;
    end
    wait_start(20, "basic_next_start");
    n_checks++;
    if (start_cyc_last[0] - scan_cyc_last !== 6)
      $display("FAIL basic_gap: scan_done to next adc_start got %0d want 6", start_cyc_last[0] - scan_cyc_last);
    else n_pass++;
    stop_scan("basic_stop");
  endtask

  task automatic test_timeout;
    int e2;
    e2 = en_cnt[2];
    data_base = 1000; no_answer = 4'b0100;
    run = 1'b1;
    wait_scan(150, "timeout_wait");
    run = 1'b0;
    n_checks++;
    if (adc_err !== 4'b0100) $display("FAIL timeout_err: got %b want 0100", adc_err);
    else n_pass++;
    n_checks++;
    if (ch_sample !== {16'd1048, 16'd382, 16'd1016, 16'd1000})
      $display("FAIL timeout_sample: got %h want 0418_017e_03f8_03e8", ch_sample);
    else n_pass++;
    n_checks++;
    if (en_cnt[2] - e2 !== 0) $display("FAIL timeout_no_enable: got %0d enables want 0", en_cnt[2] - e2);
    else n_pass++;
    n_checks++;
    if (err_chg_cyc - start_cyc_last[2] !== 9)
      $display("FAIL timeout_latency: got %0d want 9", err_chg_cyc - start_cyc_last[2]);
    else n_pass++;
    n_checks++;
    if (start_cyc_last[3] - start_cyc_last[2] !== 11)
      $display("FAIL timeout_next_ch3: got %0d want 11", start_cyc_last[3] - start_cyc_last[2]);
    else n_pass++;
    no_answer = 4'd0;
    stop_scan("timeout_stop");
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    n_checks++;
    if (adc_err !== 4'b0000) $display("FAIL err_clr: got %b want 0000", adc_err);
    else n_pass++;
  endtask

  task automatic test_skip;
    int s0[4], e0[4], st0, sc0;
    logic [3:0] sm, em;
    for (int i = 0; i < 4; i++) begin s0[i] = start_ch_cnt[i]; e0[i] = en_cnt[i]; end
    data_base = 2000; ch_skip = 4'b1010;
    run = 1'b1;
    wait_scan(100, "skip_wait");
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sm[i] = (start_ch_cnt[i] != s0[i]);
      em[i] = (en_cnt[i] != e0[i]);
    end
    n_checks++;
    if (sm !== 4'b0101) $display("FAIL skip_adc_ch: channels started %b want 0101", sm);
    else n_pass++;
    n_checks++;
    if (em !== 4'b0101) $display("FAIL skip_enable: channels enabled %b want 0101", em);
    else n_pass++;
    n_checks++;
    if (ch_sample !== {16'd1048, 16'd2032, 16'd1016, 16'd2000})
      $display("FAIL skip_sample: got %h want 0418_07f0_03f8_07d0", ch_sample);
    else n_pass++;
    stop_scan("skip_stop");
    // every channel skipped: no ADC traffic, scans still complete
    st0 = start_cnt; sc0 = scan_cnt;
    ch_skip = 4'b1111;
    run = 1'b1;
    tick(30);
    stop_scan("allskip_stop");
    n_checks++;
    if (start_cnt - st0 !== 0) $display("FAIL allskip_no_start: got %0d starts want 0", start_cnt - st0);
    else n_pass++;
    n_checks++;
    if (scan_cnt - sc0 !== 3) $display("FAIL allskip_scans: got %0d want 3", scan_cnt - sc0);
    else n_pass++;
    n_checks++;
    if (scan_cyc_last - scan_prev_cyc !== 12)
      $display("FAIL allskip_period: got %0d want 12", scan_cyc_last - scan_prev_cyc);
    else n_pass++;
    ch_skip = 4'd0;
  endtask

  task automatic test_done_at_timeout;
    delay = 8; data_base = 3000;
    run = 1'b1;
    wait_scan(150, "edge_wait");
    run = 1'b0;
    n_checks++;
    if (adc_err !== 4'b0000) $display("FAIL edge_no_err: got %b want 0000", adc_err);
    else n_pass++;
    n_checks++;
    if (ch_sample !== {16'd3048, 16'd3032, 16'd3016, 16'd3000})
      $display("FAIL edge_sample: got %h want 0be8_0bd8_0bc8_0bb8", ch_sample);
    else n_pass++;
    n_checks++;
    if (en_cyc_last[0] - start_cyc_last[0] !== 9)
      $display("FAIL edge_latency: got %0d want 9", en_cyc_last[0] - start_cyc_last[0]);
    else n_pass++;
    stop_scan("edge_stop");
    delay = 3;
  endtask

  task automatic test_stray_done;
    int e0;
    e0 = en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3];
    stray_req_n = stray_req_n + 1;
    tick(3);
    n_checks++;
    if (ch_sample !== {16'd3048, 16'd3032, 16'd3016, 16'd3000})
      $display("FAIL stray_idle_sample: got %h want 0be8_0bd8_0bc8_0bb8", ch_sample);
    else n_pass++;
    n_checks++;
    if ({busy, adc_err} !== 5'd0 || (en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3] - e0) !== 0)
      $display("FAIL stray_idle_state: busy/err %b enables %0d want 0",
               {busy, adc_err}, en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3] - e0);
    else n_pass++;
    data_base = 4000;
    run = 1'b1;
    wait_scan(100, "stray_gap_wait");
    e0 = en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3];
    stray_req_n = stray_req_n + 1;
    tick(2);
    n_checks++;
    if (ch_sample !== {16'd4048, 16'd4032, 16'd4016, 16'd4000})
      $display("FAIL stray_gap_sample: got %h want 0fd0_0fc0_0fb0_0fa0", ch_sample);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1 || (en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3] - e0) !== 0)
      $display("FAIL stray_gap_state: busy %b enables %0d want 1 and 0",
               busy, en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3] - e0);
    else n_pass++;
    stop_scan("stray_stop");
  endtask

  task automatic test_run_drop;
    int s1, sc0, st0, n;
    data_base = 5000;
    s1 = start_ch_cnt[1]; sc0 = scan_cnt; n = 0;
    run = 1'b1;
    while (start_ch_cnt[1] == s1 && n < 100) begin tick(1); n++; end
    n_checks++;
    if (start_ch_cnt[1] == s1) $display("FAIL drop_ch1_start: not seen within 100 cycles");
    else n_pass++;
    stop_scan("drop_stop");
    n_checks++;
    if (ch_sample !== {16'd5048, 16'd5032, 16'd5016, 16'd5000})
      $display("FAIL drop_sample: got %h want 13b8_13a8_1398_1388", ch_sample);
    else n_pass++;
    n_checks++;
    if (scan_cnt - sc0 !== 1) $display("FAIL drop_scan_done: got %0d want 1", scan_cnt - sc0);
    else n_pass++;
    n_checks++;
    if (busy_fall_cyc - scan_cyc_last !== 1)
      $display("FAIL drop_busy_fall: got %0d want 1", busy_fall_cyc - scan_cyc_last);
    else n_pass++;
    st0 = start_cnt;
    tick(20);
    n_checks++;
    if (start_cnt - st0 !== 0) $display("FAIL drop_no_restart: got %0d starts want 0", start_cnt - st0);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    data_base = 6000;
    run = 1'b1;
    wait_start(30, "areset_start");
    tick(1);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({adc_start, adc_ch, ch_enable, adc_err, scan_done, busy} !== 13'd0)
      $display("FAIL areset_outputs: got %b want 0",
               {adc_start, adc_ch, ch_enable, adc_err, scan_done, busy});
    else n_pass++;
    n_checks++;
    if (ch_sample !== 64'd0) $display("FAIL areset_sample: got %h want 0", ch_sample);
    else n_pass++;
    tick(3);
    rst = 1'b0;
    wait_start(10, "areset_restart");
    n_checks++;
    if (adc_ch !== 2'd0) $display("FAIL areset_restart_ch: got %0d want 0", adc_ch);
    else n_pass++;
    wait_scan(100, "areset_scan");
    n_checks++;
    if (ch_sample !== {16'd6048, 16'd6032, 16'd6016, 16'd6000})
      $display("FAIL areset_sample_after: got %h want 17a0_1790_1780_1770", ch_sample);
    else n_pass++;
    stop_scan("areset_stop");
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_timeout();
    test_skip();
    test_done_at_timeout();
    test_stray_done();
    test_run_drop();
    test_async_reset();
    n_checks++;
    if (bad_cnt !== 0) $display("FAIL enable_onehot: %0d cycles with multi-hot or start overlap, want 0", bad_cnt);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
